mem_access_unit: RTL and testbench

//  MEM-stage initiator for DataCache: takes one load/store request at a time from the pipeline and drives
//  the cache read/write port. DataCache reads combinationally and writes whole words only, so this block

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a combinational-read, word-write DataCache.
// Handles sub-word load extraction, read-modify-write for sb/sh, and alignment/range faults.
module mem_access_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] readAddress,
    input  logic [31:0] readData,
    output logic        writeEN,
    output logic [31:0] writeAddress,
    output logic [31:0] writeData
);

    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        req_bad;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val, merge_val;

    assign req_ready    = (state_q == IDLE) && rst;
    assign resp_valid   = resp_valid_q;
    assign resp_fault   = resp_fault_q;
    assign resp_rdata   = resp_rdata_q;
    assign readAddress  = addr_q;
    assign writeAddress = {addr_q[31:2], 2'b00};
    assign writeData    = wbuf_q;
    // Combinational from state so an async reset kills an in-flight write at once.
    assign writeEN      = (state_q == WRITE);

    assign req_bad = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_addr[31:2] >= 30'(MEM_WORDS));

    assign byte_sh = {addr_q[1:0], 3'b000};
    assign half_sh = {addr_q[1], 4'b0000};
    assign rd_byte = 8'(readData >> byte_sh);
    assign rd_half = 16'(readData >> half_sh);

    always_comb begin
        load_val  = readData;
        merge_val = (readData & ~(32'h0000_FFFF << half_sh)) | ({16'b0, wdata_q} << half_sh);
        case (size_q)
            2'b00: begin
                load_val  = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                merge_val = (readData & ~(32'h0000_00FF << byte_sh))
                          | ({24'b0, wdata_q[7:0]} << byte_sh);
            end
            2'b01: load_val = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        wbuf_d       = wbuf_q;
        resp_valid_d = 1'b0;
        resp_fault_d = resp_fault_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata[15:0];
                    if (req_bad)                  state_d = FAULT;
                    else if (!req_write)          state_d = LOAD;
                    else if (req_size == 2'b10) begin
                        wbuf_d  = req_wdata;
                        state_d = WRITE;
                    end else                      state_d = MERGE;
                end
            end
            LOAD: begin
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_rdata_d = load_val;
                state_d      = IDLE;
            end
            MERGE: begin
                wbuf_d  = merge_val;
                state_d = WRITE;
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_rdata_d = 32'b0;
                state_d      = IDLE;
            end
            FAULT: begin
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b1;
                resp_rdata_d = 32'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'b0;
            size_q       <= 2'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 16'b0;
            wbuf_q       <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            wbuf_q       <= wbuf_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table from the block's examples, a reset-abort
// sequence, and randomized requests checked against an array-based memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] readAddress, readData, writeAddress, writeData;
    logic        writeEN;

    logic [31:0] cmem    [256];
    logic [31:0] ref_mem [256];

    int vecs = 0;
    int errs = 0;
    logic [31:0] last_rdata = 32'b0;
    logic        last_fault = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .readAddress(readAddress), .readData(readData),
        .writeEN(writeEN), .writeAddress(writeAddress), .writeData(writeData)
    );

    // DataCache: combinational read, whole-word write on posedge
    assign readData = cmem[readAddress[9:2]];
    always @(posedge clk) if (writeEN) cmem[writeAddress[9:2]] <= writeData;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic bit ref_fault(input bit [1:0] sz, input bit [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
            || (a / 4 >= 256);
    endfunction

    task automatic ref_resp(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                            output bit [31:0] rd, output bit f, output int lat);
        int v;
        bit [31:0] word;
        f  = ref_fault(sz, a);
        rd = 32'b0;
        if (f)            lat = 2;
        else if (w)       lat = (sz == 2'd2) ? 2 : 3;
        else begin
            lat  = 2;
            word = ref_mem[a / 4];
            if (sz == 2'd0) begin
                v = int'((word >> (8 * (a % 4))) & 32'hFF);
                if (!u && v >= 128) v -= 256;
            end else if (sz == 2'd1) begin
                v = int'((word >> (16 * ((a / 2) % 2))) & 32'hFFFF);
                if (!u && v >= 32768) v -= 65536;
            end else v = int'(word);
            rd = 32'(v);
        end
    endtask

    task automatic do_req(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                          input bit [31:0] wd, input bit [31:0] er, input bit ef, input int elat,
                          input string nm);
        int wen_cnt = 0;
        int wen_k = 0;
        int waitc = 0;
        bit got = 0;
        bit [31:0] wa = 32'b0, wdv = 32'b0, nw;
        int idx = int'(a[9:2]);
        while (!req_ready && waitc < 20) begin @(negedge clk); waitc++; end
        chk({nm, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (writeEN) begin wen_cnt++; wen_k = c; wa = writeAddress; wdv = writeData; end
            if (resp_valid) begin
                got = 1;
                chk({nm, " latency"}, 32'(c), 32'(elat));
                chk({nm, " rdata"}, resp_rdata, er);
                chk({nm, " fault"}, 32'(resp_fault), 32'(ef));
                chk({nm, " ready_on_resp"}, 32'(req_ready), 32'd1);
            end else begin
                chk({nm, " busy_ready"}, 32'(req_ready), 32'd0);
                chk({nm, " rdata_hold"}, {resp_rdata[31:1], resp_rdata[0] ^ resp_fault},
                    {last_rdata[31:1], last_rdata[0] ^ last_fault});
            end
        end
        if (!got) begin
            vecs++; errs++;
            $display("FAIL %s timeout: no resp_valid within 6 cycles, expected at %0d", nm, elat);
        end
        if (w && !ef) begin
            nw = ref_mem[idx];
            if (sz == 2'd0)      nw[8 * int'(a[1:0]) +: 8]  = wd[7:0];
            else if (sz == 2'd1) nw[16 * int'(a[1]) +: 16]  = wd[15:0];
            else                 nw = wd;
            chk({nm, " wen_count"}, 32'(wen_cnt), 32'd1);
            chk({nm, " wen_cycle"}, 32'(wen_k), 32'(elat - 1));
            chk({nm, " waddr"}, wa, {a[31:2], 2'b00});
            chk({nm, " wdata"}, wdv, nw);
            ref_mem[idx] = nw;
        end else begin
            chk({nm, " no_write"}, 32'(wen_cnt), 32'd0);
        end
        chk({nm, " mem"}, cmem[idx], ref_mem[idx]);
        last_rdata = resp_rdata;
        last_fault = resp_fault;
    endtask

    typedef struct {
        bit        w;
        bit [1:0]  sz;
        bit        u;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] er;
        bit        ef;
        int        lat;
        string     nm;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit [31:0] er;
        bit        ef;
        int        lat;
        bit        w, u;
        bit [1:0]  sz;
        bit [31:0] a, wd;

        for (int i = 0; i < 256; i++) begin cmem[i] = 32'b0; ref_mem[i] = 32'b0; end
        cmem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;

        tbl.push_back('{0, 2'd2, 0, 32'h10,  32'h0,        32'h8899AABB, 0, 2, "lw_10"});
        tbl.push_back('{0, 2'd0, 0, 32'h13,  32'h0,        32'hFFFFFF88, 0, 2, "lb_13"});
        tbl.push_back('{0, 2'd0, 1, 32'h13,  32'h0,        32'h00000088, 0, 2, "lbu_13"});
        tbl.push_back('{0, 2'd1, 0, 32'h12,  32'h0,        32'hFFFF8899, 0, 2, "lh_12"});
        tbl.push_back('{0, 2'd1, 1, 32'h10,  32'h0,        32'h0000AABB, 0, 2, "lhu_10"});
        tbl.push_back('{1, 2'd0, 0, 32'h11,  32'h12345655, 32'h0,        0, 3, "sb_11"});
        tbl.push_back('{0, 2'd2, 0, 32'h10,  32'h0,        32'h889955BB, 0, 2, "lw_10_after_sb"});
        tbl.push_back('{1, 2'd2, 0, 32'h12,  32'h11111111, 32'h0,        1, 2, "sw_misalign"});
        tbl.push_back('{0, 2'd1, 0, 32'h11,  32'h0,        32'h0,        1, 2, "lh_misalign"});
        tbl.push_back('{0, 2'd2, 0, 32'h400, 32'h0,        32'h0,        1, 2, "lw_range"});
        tbl.push_back('{0, 2'd3, 0, 32'h10,  32'h0,        32'h0,        1, 2, "size11"});
        tbl.push_back('{0, 2'd2, 0, 32'h3FC, 32'h0,        32'h0,        0, 2, "lw_last_word"});
        tbl.push_back('{1, 2'd2, 0, 32'h14,  32'hDEADBEEF, 32'h0,        0, 2, "sw_14"});
        tbl.push_back('{0, 2'd2, 0, 32'h14,  32'h0,        32'hDEADBEEF, 0, 2, "lw_14_b2b"});
        tbl.push_back('{1, 2'd1, 0, 32'h16,  32'hFFFF1234, 32'h0,        0, 3, "sh_16"});
        tbl.push_back('{0, 2'd2, 0, 32'h14,  32'h0,        32'h1234BEEF, 0, 2, "lw_14_after_sh"});

        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_fault", 32'(resp_fault), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst writeEN", 32'(writeEN), 32'd0);
        chk("rst readAddress", readAddress, 32'd0);
        chk("rst writeData", writeData, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i])
            do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                   tbl[i].er, tbl[i].ef, tbl[i].lat, tbl[i].nm);

        // Reset while an sh sits in WRITE: write must be aborted, no response
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0000ABCD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort C1 writeEN", 32'(writeEN), 32'd0);
        @(negedge clk);
        chk("abort C2 writeEN", 32'(writeEN), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort writeEN_drop", 32'(writeEN), 32'd0);
        chk("abort ready_in_rst", 32'(req_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort no_resp", 32'(resp_valid), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort no_resp_after", 32'(resp_valid), 32'd0);
        chk("abort ready_after", 32'(req_ready), 32'd1);
        chk("abort mem_unchanged", cmem[8], ref_mem[8]);
        last_rdata = 32'b0; last_fault = 1'b0;
        ref_resp(0, 2'd2, 0, 32'h20, er, ef, lat);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, er, ef, lat, "lw_after_abort");

        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            u  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1:       a = 32'($urandom_range(1000, 1040));
                default: a = 32'($urandom_range(0, 127));
            endcase
            wd = $urandom();
            ref_resp(w, sz, u, a, er, ef, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(w, sz, u, a, wd, er, ef, lat, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
